// File: rtl/frame_capture.sv
// frame_capture: stream sink that stores one WIDTH x HEIGHT frame in row-major
// order and exposes a one-cycle-latency read port for readback.
module frame_capture #(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned HEIGHT = 128,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              valid_in,
    input  logic [7:0]        pixel_in,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic [15:0]       col,
    output logic [15:0]       row,
    output logic [15:0]       checksum,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [7:0]        rd_data
);

    localparam int unsigned DEPTH  = WIDTH * HEIGHT;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state;
    logic [MEM_AW-1:0] wr_addr;
    logic [7:0]        mem [0:DEPTH-1];

    logic              wr_en_c;
    logic              rd_in_range_c;

    // A beat is stored only in CAPTURE; arm and rst take precedence over it.
    assign wr_en_c       = (state == CAPTURE) && valid_in && !arm && !rst;
    assign rd_in_range_c = (32'(rd_addr) < DEPTH);

    // Capture FSM: state, position counters, checksum and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            col        <= 16'd0;
            row        <= 16'd0;
            checksum   <= 16'd0;
            wr_addr    <= '0;
        end else if (arm) begin
            state      <= CAPTURE;
            busy       <= 1'b1;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            col        <= 16'd0;
            row        <= 16'd0;
            checksum   <= 16'd0;
            wr_addr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // beats arriving before arm are discarded
                end
                CAPTURE: begin
                    if (valid_in) begin
                        checksum <= checksum + 16'(pixel_in);
                        wr_addr  <= wr_addr + MEM_AW'(1);
                        if (col == 16'(WIDTH - 1)) begin
                            col <= 16'd0;
                            if (row == 16'(HEIGHT - 1)) begin
                                row        <= 16'd0;
                                state      <= DONE;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                            end else begin
                                row <= row + 16'd1;
                            end
                        end else begin
                            col <= col + 16'd1;
                        end
                    end
                end
                DONE: begin
                    if (valid_in) begin
                        overflow <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

    // Frame RAM write port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_addr] <= pixel_in;
        end
    end

    // Registered read port; sees the pre-write contents on an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= 8'd0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_in_range_c ? mem[MEM_AW'(rd_addr)] : 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_frame_capture.sv
// tb_frame_capture: table vectors, directed corner sequences and random traffic
// checked against a queue-based frame model.
module tb_frame_capture;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned AW = 4;
    localparam int unsigned N  = W * H;

    logic          clk = 1'b0;
    logic          rst, arm, valid_in, rd_en;
    logic [7:0]    pixel_in;
    logic [AW-1:0] rd_addr;
    logic          busy, frame_done, overflow, rd_valid;
    logic [15:0]   col, row, checksum;
    logic [7:0]    rd_data;

    always #5 clk = ~clk;

    frame_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .arm(arm), .valid_in(valid_in), .pixel_in(pixel_in),
        .busy(busy), .frame_done(frame_done), .overflow(overflow),
        .col(col), .row(row), .checksum(checksum),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: a frame is the list of pixels accepted since arm.
    logic [7:0] m_mem [N];
    bit         m_known [N];
    logic [7:0] m_q [$];
    bit         m_armed = 0;
    bit         m_ovf = 0;
    bit         m_rdv = 0;
    logic [7:0] m_rdd = 8'd0;
    bit         m_rdd_known = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit a, input bit v, input logic [7:0] p,
                              input bit re, input logic [AW-1:0] ra);
        if (r) begin
            m_armed = 0; m_q.delete(); m_ovf = 0;
            m_rdv = 0; m_rdd = 8'd0; m_rdd_known = 1;
        end else begin
            m_rdv = re;
            if (re) begin
                if (int'(ra) >= int'(N)) begin
                    m_rdd = 8'd0; m_rdd_known = 1;
                end else begin
                    m_rdd = m_mem[ra]; m_rdd_known = m_known[ra];
                end
            end
            if (a) begin
                m_armed = 1; m_q.delete(); m_ovf = 0;
            end else if (m_armed && m_q.size() < N && v) begin
                m_mem[m_q.size()] = p;
                m_known[m_q.size()] = 1;
                m_q.push_back(p);
            end else if (m_armed && m_q.size() == N && v) begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        bit capturing, done;
        int sum;
        capturing = m_armed && (m_q.size() < N);
        done      = m_armed && (m_q.size() == N);
        sum = 0;
        foreach (m_q[i]) sum += int'(m_q[i]);
        chk({tag, ".busy"},       32'(busy),       32'(capturing));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(done));
        chk({tag, ".overflow"},   32'(overflow),   32'(m_ovf));
        chk({tag, ".col"},        32'(col),        capturing ? 32'(m_q.size() % W) : 32'd0);
        chk({tag, ".row"},        32'(row),        capturing ? 32'(m_q.size() / W) : 32'd0);
        chk({tag, ".checksum"},   32'(checksum),   32'(sum % 65536));
        chk({tag, ".rd_valid"},   32'(rd_valid),   32'(m_rdv));
        if (m_rdd_known) chk({tag, ".rd_data"}, 32'(rd_data), 32'(m_rdd));
    endtask

    // One clock: drive inputs, let the edge happen, then check against the model.
    task automatic cyc(input bit r, input bit a, input bit v, input logic [7:0] p,
                       input bit re, input logic [AW-1:0] ra, input string tag);
        rst = r; arm = a; valid_in = v; pixel_in = p; rd_en = re; rd_addr = ra;
        @(posedge clk);
        model_step(r, a, v, p, re, ra);
        #1;
        compare_model(tag);
    endtask

    task automatic beat(input logic [7:0] p, input string tag);
        cyc(0, 0, 1, p, 0, '0, tag);
    endtask

    task automatic idle(input string tag);
        cyc(0, 0, 0, 8'd0, 0, '0, tag);
    endtask

    task automatic rd_chk(input logic [AW-1:0] a, input logic [7:0] exp, input string tag);
        cyc(0, 0, 0, 8'd0, 1, a, tag);
        chk($sformatf("%s.rd_valid[%0d]", tag, a), 32'(rd_valid), 32'd1);
        chk($sformatf("%s.rd_data[%0d]", tag, a), 32'(rd_data), 32'(exp));
    endtask

    typedef struct {
        bit         r, a, v;
        logic [7:0] p;
        bit         re;
        logic [3:0] ra;
        bit         busy, done, ovf;
        logic [15:0] cks;
        bit         rdv;
        logic [7:0] rdd;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(bit r, bit a, bit v, logic [7:0] p, bit re, logic [3:0] ra,
                                bit eb, bit ed, bit eo, logic [15:0] ec, bit erv, logic [7:0] erd);
        vec_t e;
        e.r = r; e.a = a; e.v = v; e.p = p; e.re = re; e.ra = ra;
        e.busy = eb; e.done = ed; e.ovf = eo; e.cks = ec; e.rdv = erv; e.rdd = erd;
        tbl.push_back(e);
    endfunction

    initial begin
        int gap;
        foreach (m_known[i]) m_known[i] = 0;
        rst = 1; arm = 0; valid_in = 0; pixel_in = 0; rd_en = 0; rd_addr = 0;

        // Test 1, 3 and 6 as a vector table.
        add(1, 0, 0, 8'd0, 0, 4'd0,  0, 0, 0, 16'd0, 0, 8'd0);
        add(0, 1, 0, 8'd0, 0, 4'd0,  1, 0, 0, 16'd0, 0, 8'd0);
        for (int k = 1; k <= 8; k++)
            add(0, 0, 1, 8'(k), 0, 4'd0, k < 8, k == 8, 0, 16'(k * (k + 1) / 2), 0, 8'd0);
        for (int a = 0; a < 8; a++)
            add(0, 0, 0, 8'd0, 1, 4'(a), 0, 1, 0, 16'd36, 1, 8'(a + 1));
        add(0, 0, 0, 8'd0,  0, 4'd0, 0, 1, 0, 16'd36, 0, 8'd8);
        add(0, 0, 1, 8'hFF, 0, 4'd0, 0, 1, 1, 16'd36, 0, 8'd8);
        add(0, 0, 1, 8'hFF, 1, 4'd7, 0, 1, 1, 16'd36, 1, 8'd8);
        add(0, 0, 0, 8'd0,  1, 4'd8, 0, 1, 1, 16'd36, 1, 8'd0);
        add(0, 1, 0, 8'd0,  0, 4'd0, 1, 0, 0, 16'd0,  0, 8'd0);
        add(0, 0, 1, 8'h55, 1, 4'd0, 1, 0, 0, 16'h55, 1, 8'd1);
        add(0, 0, 0, 8'd0,  1, 4'd0, 1, 0, 0, 16'h55, 1, 8'h55);

        foreach (tbl[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            cyc(tbl[i].r, tbl[i].a, tbl[i].v, tbl[i].p, tbl[i].re, tbl[i].ra, t);
            chk({t, ".tbl_busy"},     32'(busy),       32'(tbl[i].busy));
            chk({t, ".tbl_done"},     32'(frame_done), 32'(tbl[i].done));
            chk({t, ".tbl_overflow"}, 32'(overflow),   32'(tbl[i].ovf));
            chk({t, ".tbl_checksum"}, 32'(checksum),   32'(tbl[i].cks));
            chk({t, ".tbl_rd_valid"}, 32'(rd_valid),   32'(tbl[i].rdv));
            chk({t, ".tbl_rd_data"},  32'(rd_data),    32'(tbl[i].rdd));
        end

        // Test 2: IDLE beats ignored, gapped capture gives the same frame.
        cyc(1, 0, 0, 8'd0, 0, '0, "t2_rst");
        for (int i = 0; i < 4; i++) beat(8'($urandom_range(0, 255)), "t2_idle_beat");
        chk("t2_idle_checksum", 32'(checksum), 32'd0);
        chk("t2_idle_col", 32'(col), 32'd0);
        cyc(0, 1, 0, 8'd0, 0, '0, "t2_arm");
        for (int k = 1; k <= 8; k++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) idle("t2_gap");
            beat(8'(k), "t2_beat");
        end
        chk("t2_done", 32'(frame_done), 32'd1);
        chk("t2_checksum", 32'(checksum), 32'd36);
        for (int a = 0; a < 8; a++) rd_chk(AW'(a), 8'(a + 1), "t2_rd");

        // Test 4: re-arm mid-frame with a beat on the arm cycle.
        cyc(0, 1, 0, 8'd0, 0, '0, "t4_arm");
        for (int i = 0; i < 5; i++) beat(8'($urandom_range(0, 255)), "t4_pre");
        cyc(0, 1, 1, 8'hAA, 0, '0, "t4_rearm");
        chk("t4_rearm_checksum", 32'(checksum), 32'd0);
        chk("t4_rearm_col", 32'(col), 32'd0);
        for (int i = 0; i < 8; i++) beat(8'h10, "t4_beat");
        chk("t4_done", 32'(frame_done), 32'd1);
        chk("t4_checksum", 32'(checksum), 32'h80);
        for (int a = 0; a < 8; a++) rd_chk(AW'(a), 8'h10, "t4_rd");

        // Test 5: reset mid-capture, then a clean capture.
        cyc(0, 1, 0, 8'd0, 0, '0, "t5_arm");
        for (int i = 0; i < 3; i++) beat(8'(7 + i), "t5_pre");
        chk("t5_pre_col", 32'(col), 32'd3);
        cyc(1, 0, 0, 8'd0, 0, '0, "t5_rst");
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_col", 32'(col), 32'd0);
        chk("t5_row", 32'(row), 32'd0);
        chk("t5_checksum", 32'(checksum), 32'd0);
        cyc(0, 1, 0, 8'd0, 0, '0, "t5_arm2");
        for (int i = 0; i < 8; i++) beat(8'(3 * i + 2), "t5_beat");
        chk("t5_done", 32'(frame_done), 32'd1);
        chk("t5_checksum2", 32'(checksum), 32'd100);
        for (int a = 0; a < 8; a++) rd_chk(AW'(a), 8'(3 * a + 2), "t5_rd");

        // Random traffic checked against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)),
                $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
